proc_imem_fetch_tracker: RTL and testbench
==========================================

Name: proc_imem_fetch_tracker

Overview:
- Sits between the fetch-stage control and the instruction memory port.
- Issues imem requests and tracks up to p_max_outstanding in-flight requests.
- On a squash (redirect), it drops every stale in-flight response, not just one. Responses are assumed to return in order.
- Successor to the single-entry imem drop unit; lets fetch run ahead with multiple outstanding requests.

Parameters:
- p_req_nbits, 77, request message width (mem_req_4B_t)
- p_resp_nbits, 47, response message width (mem_resp_4B_t)
- p_max_outstanding, 4, max in-flight requests (>=1)
- c_cnt_nbits, $clog2(p_max_outstanding+1), derived local width of the counters

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-low reset (block resets while reset==0)
- squash  input  1  one-cycle pulse: all requests already in flight become stale
- req_in_msg  input  p_req_nbits  request from fetch
- req_in_val  input  1  request valid
- req_in_rdy  output  1  request ready
- req_out_msg  output  p_req_nbits  request to imem (equals req_in_msg)
- req_out_val  output  1  request valid to imem
- req_out_rdy  input  1  imem ready
- resp_in_msg  input  p_resp_nbits  response from imem
- resp_in_val  input  1  response valid
- resp_in_rdy  output  1  response ready to imem
- resp_out_msg  output  p_resp_nbits  response to fetch (equals resp_in_msg)
- resp_out_val  output  1  response valid to fetch
- resp_out_rdy  input  1  fetch ready
- num_outstanding  output  c_cnt_nbits  registered in-flight count
- idle  output  1  high when num_outstanding==0

Behaviour:
- Registers: outstanding (0..p_max_outstanding) and pending_drop (0..outstanding). Both clear asynchronously when reset==0.
- Outputs during reset: req_in_rdy=0, req_out_val=0, resp_out_val=0, resp_in_rdy=1, num_outstanding=0, idle=1.
- Request path is zero latency and combinational:
  - full = (outstanding == p_max_outstanding), from the registered count only; a same-cycle response does not free a slot.
  - req_out_val = req_in_val && !full
  - req_in_rdy = req_out_rdy && !full
  - req_fire = req_out_val && req_out_rdy
- Response path:
  - drop_now = squash || pending_drop != 0 || outstanding == 0
  - resp_out_val = resp_in_val && !drop_now
  - resp_in_rdy = drop_now ? 1 : resp_out_rdy
  - resp_fire = resp_in_val && resp_in_rdy
  - A dropped response is consumed and never shown to fetch.
- Counter updates:
  - outstanding_next = outstanding + req_fire - (resp_fire && outstanding != 0). It saturates at 0 and can never exceed p_max_outstanding.
  - If squash: pending_drop_next = outstanding - (resp_fire && outstanding != 0). A request fired in the squash cycle is the redirect fetch; it is NOT stale and is not counted.
  - Else: pending_drop_next = pending_drop - (resp_fire && pending_drop != 0).
- Boundary cases:
  - Squash while pending_drop > 0: pending_drop is reloaded from outstanding. Stale work is not double-counted, because pending_drop <= outstanding always holds.
  - Squash with outstanding==0: no effect.
  - Back-to-back squashes: each reload uses the current outstanding.
  - Response with outstanding==0 (spurious, e.g. after reset mid-operation): consumed and dropped; counters unchanged.
  - Full with simultaneous response: the request is still blocked this cycle and accepted the next cycle.
- Reset mid-operation: counters clear immediately. Responses to pre-reset requests are absorbed as spurious.

Optional Feature:
- Macro: PROC_IMEM_FETCH_TRACKER_STATS_EN
- When defined, the block adds three outputs, stat_issued, stat_dropped and stat_spurious (32-bit each, wrapping, reset to 0):
  - stat_issued increments on req_fire.
  - stat_dropped increments on each dropped resp_fire where outstanding != 0.
  - stat_spurious increments on each resp_fire where outstanding == 0.
- When not defined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Basic flow: issue 4 requests A0..A3 with memory ready, return 4 responses in order -> all 4 seen on resp_out in order; num_outstanding goes 1,2,3,4,3,2,1,0; idle=1 at the end.
- Full: p_max_outstanding=4, hold responses, offer 5th request -> req_in_rdy=0 while full; after one response, 5th request accepted on the next cycle.
- Squash: 3 in flight, pulse squash while issuing redirect request R -> next 3 responses dropped (resp_out_val=0, resp_in_rdy=1); R's response delivered; pending_drop reaches 0.
- Squash same cycle as response: 2 in flight, resp arrives with squash -> that response dropped, pending_drop=1, the following response also dropped.
- Back-to-back squash: 4 in flight, squash, one response dropped, issue 1 request, squash again -> pending_drop=4 (3 old + 1 new); all 4 dropped.
- Async reset mid-operation: 3 in flight, drive reset=0 mid-cycle -> num_outstanding=0 immediately; 3 late responses consumed and dropped (stat_spurious=3 with STATS_EN).

Source files
------------

// File: rtl/proc_imem_fetch_tracker_if.sv
// Fetch <-> imem handshake bundle seen by the fetch tracker.
// master drives the fetch-side request/ready and imem-side response; slave is the tracker.
interface proc_imem_fetch_tracker_if #(
   parameter int p_req_nbits  = 77,
   parameter int p_resp_nbits = 47
);
   logic [p_req_nbits-1:0]  req_in_msg;
   logic                    req_in_val;
   logic                    req_in_rdy;
   logic [p_req_nbits-1:0]  req_out_msg;
   logic                    req_out_val;
   logic                    req_out_rdy;
   logic [p_resp_nbits-1:0] resp_in_msg;
   logic                    resp_in_val;
   logic                    resp_in_rdy;
   logic [p_resp_nbits-1:0] resp_out_msg;
   logic                    resp_out_val;
   logic                    resp_out_rdy;

   modport master (
      output req_in_msg, req_in_val, req_out_rdy, resp_in_msg, resp_in_val, resp_out_rdy,
      input  req_in_rdy, req_out_msg, req_out_val, resp_in_rdy, resp_out_msg, resp_out_val
   );

   modport slave (
      input  req_in_msg, req_in_val, req_out_rdy, resp_in_msg, resp_in_val, resp_out_rdy,
      output req_in_rdy, req_out_msg, req_out_val, resp_in_rdy, resp_out_msg, resp_out_val
   );
endinterface

// File: rtl/proc_imem_fetch_tracker.sv
// Tracks up to p_max_outstanding in-order imem requests and drops every stale response after a squash.
// Optional counters stat_issued/stat_dropped/stat_spurious exist only with PROC_IMEM_FETCH_TRACKER_STATS_EN.
module proc_imem_fetch_tracker #(
   parameter int p_req_nbits       = 77,
   parameter int p_resp_nbits      = 47,
   parameter int p_max_outstanding = 4,
   localparam int c_cnt_nbits      = $clog2(p_max_outstanding + 1)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          squash,
   proc_imem_fetch_tracker_if.slave      bus,
   output logic [c_cnt_nbits-1:0]        num_outstanding,
   output logic                          idle
`ifdef PROC_IMEM_FETCH_TRACKER_STATS_EN
   ,
   output logic [31:0]                   stat_issued,
   output logic [31:0]                   stat_dropped,
   output logic [31:0]                   stat_spurious
`endif
);

   localparam logic [c_cnt_nbits-1:0] c_max = c_cnt_nbits'(p_max_outstanding);
   localparam logic [c_cnt_nbits-1:0] c_one = c_cnt_nbits'(1);

   logic [c_cnt_nbits-1:0]  r_outstanding;
   logic [c_cnt_nbits-1:0]  r_pending_drop;
   logic [c_cnt_nbits-1:0]  w_outstanding_next;
   logic [c_cnt_nbits-1:0]  w_pending_drop_next;
   logic [p_req_nbits-1:0]  w_req_msg;
   logic [p_resp_nbits-1:0] w_resp_msg;
   logic                    w_run;
   logic                    w_full;
   logic                    w_drop_now;
   logic                    w_req_fire;
   logic                    w_resp_fire;
   logic                    w_resp_dec;

   // reset is active-low; while asserted the request side is closed and responses are swallowed
   assign w_run      = reset;
   assign w_full     = (r_outstanding == c_max);
   assign w_drop_now = !w_run || squash || (r_pending_drop != '0) || (r_outstanding == '0);

   assign w_req_msg        = bus.req_in_msg;
   assign bus.req_out_msg  = w_req_msg;
   assign bus.req_out_val  = w_run && bus.req_in_val && !w_full;
   assign bus.req_in_rdy   = w_run && bus.req_out_rdy && !w_full;

   assign w_resp_msg       = bus.resp_in_msg;
   assign bus.resp_out_msg = w_resp_msg;
   assign bus.resp_out_val = bus.resp_in_val && !w_drop_now;
   assign bus.resp_in_rdy  = w_drop_now ? 1'b1 : bus.resp_out_rdy;

   assign w_req_fire  = bus.req_out_val && bus.req_out_rdy;
   assign w_resp_fire = bus.resp_in_val && bus.resp_in_rdy;
   assign w_resp_dec  = w_resp_fire && (r_outstanding != '0);

   always_comb begin
      w_outstanding_next  = r_outstanding;
      w_pending_drop_next = r_pending_drop;
      if (w_req_fire)
         w_outstanding_next = w_outstanding_next + c_one;
      if (w_resp_dec)
         w_outstanding_next = w_outstanding_next - c_one;
      // the request fired alongside a squash is the redirect itself, so it is not marked stale
      if (squash)
         w_pending_drop_next = w_resp_dec ? (r_outstanding - c_one) : r_outstanding;
      else if (w_resp_fire && (r_pending_drop != '0))
         w_pending_drop_next = r_pending_drop - c_one;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_outstanding  <= '0;
         r_pending_drop <= '0;
      end else begin
         r_outstanding  <= w_outstanding_next;
         r_pending_drop <= w_pending_drop_next;
      end
   end

   assign num_outstanding = r_outstanding;
   assign idle            = (r_outstanding == '0);

`ifdef PROC_IMEM_FETCH_TRACKER_STATS_EN
   logic [31:0] r_stat_issued;
   logic [31:0] r_stat_dropped;
   logic [31:0] r_stat_spurious;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_issued   <= '0;
         r_stat_dropped  <= '0;
         r_stat_spurious <= '0;
      end else begin
         if (w_req_fire)
            r_stat_issued <= r_stat_issued + 32'd1;
         if (w_resp_fire && w_drop_now && (r_outstanding != '0))
            r_stat_dropped <= r_stat_dropped + 32'd1;
         if (w_resp_fire && (r_outstanding == '0))
            r_stat_spurious <= r_stat_spurious + 32'd1;
      end
   end

   assign stat_issued   = r_stat_issued;
   assign stat_dropped  = r_stat_dropped;
   assign stat_spurious = r_stat_spurious;
`endif

endmodule

// File: tb/tb_proc_imem_fetch_tracker.sv
// Directed bench for proc_imem_fetch_tracker (p_max_outstanding=4); stats checks compile in with PROC_IMEM_FETCH_TRACKER_STATS_EN.
module tb_proc_imem_fetch_tracker;

   logic       clk;
   logic       reset;
   logic       squash;
   logic [2:0] num_outstanding;
   logic       idle;
   int         total;
   int         bad;
`ifdef PROC_IMEM_FETCH_TRACKER_STATS_EN
   logic [31:0] stat_issued;
   logic [31:0] stat_dropped;
   logic [31:0] stat_spurious;
`endif

   proc_imem_fetch_tracker_if #(.p_req_nbits(77), .p_resp_nbits(47)) bus ();

   proc_imem_fetch_tracker #(
      .p_req_nbits(77),
      .p_resp_nbits(47),
      .p_max_outstanding(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .squash(squash),
      .bus(bus),
      .num_outstanding(num_outstanding),
      .idle(idle)
`ifdef PROC_IMEM_FETCH_TRACKER_STATS_EN
      ,
      .stat_issued(stat_issued),
      .stat_dropped(stat_dropped),
      .stat_spurious(stat_spurious)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      squash           = 1'b0;
      bus.req_in_val   = 1'b0;
      bus.req_out_rdy  = 1'b1;
      bus.resp_in_val  = 1'b0;
      bus.resp_out_rdy = 1'b1;
   endtask

   // one accepted request; checks pass-through then the registered count after the edge
   task automatic issue(input logic [76:0] m, input logic [2:0] exp_num);
      bus.req_in_val = 1'b1;
      bus.req_in_msg = m;
      #1;
      chk("issue_req_out_val", 80'(bus.req_out_val), 80'(1'b1));
      chk("issue_req_out_msg", 80'(bus.req_out_msg), 80'(m));
      tick();
      bus.req_in_val = 1'b0;
      chk("issue_num_outstanding", 80'(num_outstanding), 80'(exp_num));
   endtask

   // one response from imem; deliver says whether fetch should see it
   task automatic respond(input logic [46:0] m, input logic deliver, input logic [2:0] exp_num);
      bus.resp_in_val = 1'b1;
      bus.resp_in_msg = m;
      #1;
      chk("resp_out_val", 80'(bus.resp_out_val), 80'(deliver));
      chk("resp_in_rdy", 80'(bus.resp_in_rdy), 80'(1'b1));
      if (deliver)
         chk("resp_out_msg", 80'(bus.resp_out_msg), 80'(m));
      tick();
      bus.resp_in_val = 1'b0;
      chk("resp_num_outstanding", 80'(num_outstanding), 80'(exp_num));
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // held in reset with traffic offered on both sides
      reset            = 1'b0;
      squash           = 1'b0;
      bus.req_in_val   = 1'b1;
      bus.req_in_msg   = 77'h1;
      bus.req_out_rdy  = 1'b1;
      bus.resp_in_val  = 1'b1;
      bus.resp_in_msg  = 47'h2;
      bus.resp_out_rdy = 1'b1;
      #2;
      chk("rst_req_in_rdy", 80'(bus.req_in_rdy), 80'(1'b0));
      chk("rst_req_out_val", 80'(bus.req_out_val), 80'(1'b0));
      chk("rst_resp_out_val", 80'(bus.resp_out_val), 80'(1'b0));
      chk("rst_resp_in_rdy", 80'(bus.resp_in_rdy), 80'(1'b1));
      chk("rst_num_outstanding", 80'(num_outstanding), 80'(3'd0));
      chk("rst_idle", 80'(idle), 80'(1'b1));
      @(posedge clk);
      #3;
      quiet();
      reset = 1'b1;
      tick();

      // basic flow, first response held off by fetch backpressure
      issue(77'hA0, 3'd1);
      issue(77'hA1, 3'd2);
      issue(77'hA2, 3'd3);
      issue(77'hA3, 3'd4);
      chk("full_idle", 80'(idle), 80'(1'b0));
      bus.resp_out_rdy = 1'b0;
      bus.resp_in_val  = 1'b1;
      bus.resp_in_msg  = 47'hB0;
      #1;
      chk("bp_resp_out_val", 80'(bus.resp_out_val), 80'(1'b1));
      chk("bp_resp_in_rdy", 80'(bus.resp_in_rdy), 80'(1'b0));
      tick();
      chk("bp_num_outstanding", 80'(num_outstanding), 80'(3'd4));
      bus.resp_out_rdy = 1'b1;
      respond(47'hB0, 1'b1, 3'd3);
      respond(47'hB1, 1'b1, 3'd2);
      respond(47'hB2, 1'b1, 3'd1);
      respond(47'hB3, 1'b1, 3'd0);
      chk("basic_idle", 80'(idle), 80'(1'b1));

      // full: fifth request blocked, still blocked in the response cycle, accepted after
      issue(77'hC0, 3'd1);
      issue(77'hC1, 3'd2);
      issue(77'hC2, 3'd3);
      issue(77'hC3, 3'd4);
      bus.req_in_val = 1'b1;
      bus.req_in_msg = 77'hC4;
      #1;
      chk("full_req_in_rdy", 80'(bus.req_in_rdy), 80'(1'b0));
      chk("full_req_out_val", 80'(bus.req_out_val), 80'(1'b0));
      tick();
      chk("full_hold_num", 80'(num_outstanding), 80'(3'd4));
      bus.resp_in_val = 1'b1;
      bus.resp_in_msg = 47'hD0;
      #1;
      chk("full_resp_req_out_val", 80'(bus.req_out_val), 80'(1'b0));
      chk("full_resp_out_val", 80'(bus.resp_out_val), 80'(1'b1));
      tick();
      bus.resp_in_val = 1'b0;
      chk("full_after_resp_num", 80'(num_outstanding), 80'(3'd3));
      #1;
      chk("full_retry_req_out_val", 80'(bus.req_out_val), 80'(1'b1));
      chk("full_retry_req_in_rdy", 80'(bus.req_in_rdy), 80'(1'b1));
      tick();
      bus.req_in_val = 1'b0;
      chk("full_retry_num", 80'(num_outstanding), 80'(3'd4));
      respond(47'hD1, 1'b1, 3'd3);
      respond(47'hD2, 1'b1, 3'd2);
      respond(47'hD3, 1'b1, 3'd1);
      respond(47'hD4, 1'b1, 3'd0);

      // squash with 3 in flight while the redirect request fires
      issue(77'hE0, 3'd1);
      issue(77'hE1, 3'd2);
      issue(77'hE2, 3'd3);
      squash = 1'b1;
      issue(77'hEF, 3'd4);
      squash = 1'b0;
      bus.resp_out_rdy = 1'b0;
      respond(47'hE0, 1'b0, 3'd3);
      respond(47'hE1, 1'b0, 3'd2);
      respond(47'hE2, 1'b0, 3'd1);
      bus.resp_out_rdy = 1'b1;
      respond(47'hEF, 1'b1, 3'd0);

      // squash in the same cycle as a response
      issue(77'h10, 3'd1);
      issue(77'h11, 3'd2);
      squash = 1'b1;
      respond(47'h10, 1'b0, 3'd1);
      squash = 1'b0;
      respond(47'h11, 1'b0, 3'd0);
      chk("sq_resp_idle", 80'(idle), 80'(1'b1));

      // squash with nothing in flight has no lasting effect
      squash = 1'b1;
      tick();
      squash = 1'b0;
      chk("sq_zero_num", 80'(num_outstanding), 80'(3'd0));
      issue(77'h20, 3'd1);
      respond(47'h20, 1'b1, 3'd0);

      // back-to-back squashes: reload from current count (3 old + 1 new)
      issue(77'h30, 3'd1);
      issue(77'h31, 3'd2);
      issue(77'h32, 3'd3);
      issue(77'h33, 3'd4);
      squash = 1'b1;
      tick();
      squash = 1'b0;
      respond(47'h30, 1'b0, 3'd3);
      issue(77'h34, 3'd4);
      squash = 1'b1;
      tick();
      squash = 1'b0;
      respond(47'h31, 1'b0, 3'd3);
      respond(47'h32, 1'b0, 3'd2);
      respond(47'h33, 1'b0, 3'd1);
      respond(47'h34, 1'b0, 3'd0);
      issue(77'h35, 3'd1);
      respond(47'h35, 1'b1, 3'd0);
`ifdef PROC_IMEM_FETCH_TRACKER_STATS_EN
      chk("stat_dropped_pre_reset", 80'(stat_dropped), 80'(32'd10));
`endif

      // async reset mid-cycle with 3 in flight; late responses are spurious
      issue(77'h40, 3'd1);
      issue(77'h41, 3'd2);
      issue(77'h42, 3'd3);
      #3;
      reset = 1'b0;
      #1;
      chk("async_rst_num", 80'(num_outstanding), 80'(3'd0));
      chk("async_rst_idle", 80'(idle), 80'(1'b1));
      #2;
      reset = 1'b1;
      tick();
      respond(47'h40, 1'b0, 3'd0);
      respond(47'h41, 1'b0, 3'd0);
      respond(47'h42, 1'b0, 3'd0);
      chk("post_rst_idle", 80'(idle), 80'(1'b1));
`ifdef PROC_IMEM_FETCH_TRACKER_STATS_EN
      chk("stat_spurious", 80'(stat_spurious), 80'(32'd3));
      chk("stat_dropped_post_reset", 80'(stat_dropped), 80'(32'd0));
      chk("stat_issued_post_reset", 80'(stat_issued), 80'(32'd0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
